bus_fifo_terminal: RTL

Synthesizable endpoint that sits at one port of the `bs_gnrtr_n_rbtr` bus and is the device side of its FIFO handshake. The bus reads a show-ahead transmit FIFO through `pndng`/`pop`/`D_pop` and writes a receive FIFO through `push`/`D_push`. A local user side loads outgoing packets and drains incoming ones. One instance is placed per bus port, replacing the behavioural FIFO models currently used in the testbench.

---
 rtl/bus_term_pkg.sv | 21 ++
 rtl/circ_fifo.sv | 62 ++++++
 rtl/bus_fifo_terminal.sv | 83 ++++++++
 3 files changed

// File: rtl/bus_term_pkg.sv
// Shared definitions for the bus FIFO terminal:
// packet layout, error flag indices and helpers.
package bus_term_pkg;

   localparam int PKT_W = 16;
   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

   typedef logic [2:0] err_t;

   localparam int ERR_TX_OVF = 0;
   localparam int ERR_RX_OVF = 1;
   localparam int ERR_POP_EMPTY = 2;

   function automatic logic [ID_W-1:0] pkt_dest(
      input logic [PKT_W-1:0] pkt
   );
      return pkt[PKT_W-1 -: ID_W];
   endfunction

endpackage

// File: rtl/circ_fifo.sv
// Show-ahead circular buffer with occupancy count
// and single-cycle overflow/underflow pulses.
module circ_fifo #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr,
   input  logic [width-1:0]         din,
   input  logic                     rd,
   output logic [width-1:0]         dout,
   output logic [$clog2(depth):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     ovf,
   output logic                     udf
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [width-1:0] mem [depth];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             wr_ok;
   logic             rd_ok;

   assign full  = (cnt == CW'(depth));
   assign empty = (cnt == '0);

   // A read frees a slot in the same cycle, so a full write may proceed.
   assign rd_ok = rd && !empty;
   assign wr_ok = wr && (!full || rd);
   assign ovf   = wr && full && !rd;
   assign udf   = rd && empty;

   assign dout  = mem[rd_ptr];
   assign count = cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < depth; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         cnt <= cnt + CW'(wr_ok) - CW'(rd_ok);
      end
   end

endmodule

// File: rtl/bus_fifo_terminal.sv
// Bus port endpoint: transmit FIFO read by the bus,
// receive FIFO written by the bus, sticky error flags.
module bus_fifo_terminal
   import bus_term_pkg::*;
#(
   parameter int pckg_sz = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     pndng,
   output logic [pckg_sz-1:0]       D_pop,
   input  logic                     pop,
   input  logic                     push,
   input  logic [pckg_sz-1:0]       D_push,
   input  logic                     tx_wr,
   input  logic [pckg_sz-1:0]       tx_data,
   output logic                     tx_full,
   input  logic                     rx_rd,
   output logic [pckg_sz-1:0]       rx_data,
   output logic                     rx_empty,
   output logic [$clog2(depth):0]   rx_count,
   output logic [2:0]               err
);

   logic                   tx_empty;
   logic                   tx_ovf;
   logic                   tx_udf;
   logic                   rx_full_unused;
   logic                   rx_ovf;
   logic                   rx_udf_unused;
   logic [$clog2(depth):0] tx_count_unused;
   err_t                   err_q;

   circ_fifo #(
      .width (pckg_sz),
      .depth (depth)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .wr    (tx_wr),
      .din   (tx_data),
      .rd    (pop),
      .dout  (D_pop),
      .count (tx_count_unused),
      .full  (tx_full),
      .empty (tx_empty),
      .ovf   (tx_ovf),
      .udf   (tx_udf)
   );

   circ_fifo #(
      .width (pckg_sz),
      .depth (depth)
   ) u_rx (
      .clk   (clk),
      .reset (reset),
      .wr    (push),
      .din   (D_push),
      .rd    (rx_rd),
      .dout  (rx_data),
      .count (rx_count),
      .full  (rx_full_unused),
      .empty (rx_empty),
      .ovf   (rx_ovf),
      .udf   (rx_udf_unused)
   );

   assign pndng = !tx_empty;
   assign err   = err_q;

   // Reading an empty receive FIFO is harmless, so it is not flagged.
   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= '0;
      end else begin
         if (tx_ovf) err_q[ERR_TX_OVF] <= 1'b1;
         if (rx_ovf) err_q[ERR_RX_OVF] <= 1'b1;
         if (tx_udf) err_q[ERR_POP_EMPTY] <= 1'b1;
      end
   end

endmodule
